// File: rtl/fb_loader_if.sv
// rtl/fb_loader_if.sv - byte stream input and framebuffer write port of fb_loader
interface fb_loader_if #(
  parameter int ADDR_W = 16
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [2:0]        wr_data;

  // Upstream byte source / framebuffer observer side
  modport master (
    output in_data, in_valid,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  // Loader side
  modport slave (
    input  in_data, in_valid,
    output in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/fb_loader.sv
// rtl/fb_loader.sv - unpacks a synced byte stream into sequential 3-bit framebuffer writes
module fb_loader #(
  parameter int          H_PIX     = 320,
  parameter int          V_PIX     = 120,
  parameter int          ADDR_W    = 16,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  fb_loader_if.slave bus,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] frame_count
);

  // Pixels are written two per byte in raster order, so one linear counter
  // covers row and column; the frame ends when the high pixel lands on the
  // last address (the pixel count is even, so that is always a high pixel).
  localparam int                N_PIX     = H_PIX * V_PIX;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PIX - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BYTE,
    WR_HI
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_hi;
  logic [2:0]        hi_buf;
  logic              xfer;
  logic              unused_bits;

  // Bits 7 and 3 of each byte carry no pixel data
  assign unused_bits = &{1'b0, bus.in_data[7], bus.in_data[3]};

  // Only the high-pixel write cycle stalls the stream
  assign bus.in_ready = (state != WR_HI);
  assign xfer         = bus.in_valid && bus.in_ready;
  assign addr_hi      = addr + ADDR_W'(1);

  // Frame FSM with registered write port and status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      addr        <= '0;
      hi_buf      <= '0;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      bus.wr_en  <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (xfer && bus.in_data == SYNC_BYTE) begin
            addr  <= '0;
            busy  <= 1'b1;
            state <= WAIT_BYTE;
          end
        end
        WAIT_BYTE: begin
          // A sync-valued byte here is plain pixel data; no mid-frame resync
          if (xfer) begin
            bus.wr_en   <= 1'b1;
            bus.wr_addr <= addr;
            bus.wr_data <= bus.in_data[2:0];
            hi_buf      <= bus.in_data[6:4];
            state       <= WR_HI;
          end
        end
        WR_HI: begin
          bus.wr_en   <= 1'b1;
          bus.wr_addr <= addr_hi;
          bus.wr_data <= hi_buf;
          addr        <= addr + ADDR_W'(2);
          if (addr_hi == LAST_ADDR) begin
            frame_done  <= 1'b1;
            busy        <= 1'b0;
            frame_count <= frame_count + 8'd1;
            state       <= IDLE;
          end else begin
            state <= WAIT_BYTE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_loader.sv
// tb/tb_fb_loader.sv - directed self-checking bench for fb_loader on a reduced 16x6 frame
module tb_fb_loader;
  localparam int H_PIX  = 16;
  localparam int V_PIX  = 6;
  localparam int ADDR_W = 8;
  localparam int N_PIX  = H_PIX * V_PIX;
  localparam int N_BYTE = N_PIX / 2;
  localparam logic [7:0] SYNC = 8'hA5;

  logic       clk;
  logic       reset;
  logic       busy;
  logic       frame_done;
  logic [7:0] frame_count;

  fb_loader_if #(.ADDR_W(ADDR_W)) bus ();

  fb_loader #(
    .H_PIX(H_PIX), .V_PIX(V_PIX), .ADDR_W(ADDR_W), .SYNC_BYTE(SYNC)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .busy(busy), .frame_done(frame_done), .frame_count(frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_q[$];
  int exp_addr = 0;
  int wr_count = 0;
  int done_count = 0;
  int run_len = 0;
  int run_at_done = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Write scoreboard: every write must match the next expected pixel
  always @(negedge clk) begin
    int e;
    if (bus.wr_en === 1'b1) begin
      run_len++;
      wr_count++;
      if (exp_q.size() == 0) begin
        check("spurious_write", 32'(bus.wr_addr), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(bus.wr_addr), 32'(e >> 3));
        check("wr_data", 32'(bus.wr_data), 32'(e & 7));
      end
    end else begin
      run_len = 0;
    end
    if (frame_done === 1'b1) begin
      done_count++;
      run_at_done = run_len;
      check("done_wr_en", 32'(bus.wr_en), 32'd1);
      check("done_addr", 32'(bus.wr_addr), 32'(N_PIX - 1));
      check("done_busy", 32'(busy), 32'd0);
      check("done_in_ready", 32'(bus.in_ready), 32'd1);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [7:0] pat(input int k, input int seed);
    logic [7:0] v;
    if (k == 0) return 8'h52;
    if (k == 10) return 8'hA5;
    v = 8'(k * 37 + seed);
    return v;
  endfunction

  task automatic send(input logic [7:0] b, input int gap);
    int guard;
    bus.in_valid = 1'b0;
    repeat (gap) step();
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 20) begin
      step();
      guard++;
    end
    if (bus.in_ready !== 1'b1) check("ready_timeout", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic send_data(input logic [7:0] b, input int gap);
    exp_q.push_back(exp_addr * 8 + int'(b[2:0]));
    exp_q.push_back((exp_addr + 1) * 8 + int'(b[6:4]));
    exp_addr += 2;
    send(b, gap);
  endtask

  task automatic send_sync(input int gap);
    send(SYNC, gap);
    exp_addr = 0;
    check("sync_busy", 32'(busy), 32'd1);
    check("sync_in_ready", 32'(bus.in_ready), 32'd1);
    check("sync_no_write", 32'(bus.wr_en), 32'd0);
  endtask

  task automatic wait_done(input int d0);
    int guard;
    guard = 0;
    while (done_count == d0 && guard < 10) begin
      step();
      guard++;
    end
    check("frame_done_once", 32'(done_count - d0), 32'd1);
  endtask

  task automatic send_frame(input int seed, input int maxgap, input bit chk_ready, input int hold_k);
    int d0, w0;
    d0 = done_count;
    w0 = wr_count;
    send_sync(0);
    for (int k = 0; k < N_BYTE; k++) begin
      send_data(pat(k, seed), int'($urandom_range(0, maxgap)));
      if (chk_ready) check("ready_low_after_accept", 32'(bus.in_ready), 32'd0);
      if (k == hold_k) begin
        repeat (6) step();
        check("hold_wr_en", 32'(bus.wr_en), 32'd0);
        check("hold_busy", 32'(busy), 32'd1);
        check("hold_in_ready", 32'(bus.in_ready), 32'd1);
      end
    end
    wait_done(d0);
    if (maxgap == 0 && hold_k < 0) check("b2b_run", 32'(run_at_done), 32'(N_PIX));
    check("frame_writes", 32'(wr_count - w0), 32'(N_PIX));
    check("frame_busy_after", 32'(busy), 32'd0);
    check("frame_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) step();
    reset = 1'b0;
    repeat (10) step();
    check("rst_wr_en", 32'(bus.wr_en), 32'd0);
    check("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    check("rst_wr_data", 32'(bus.wr_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Garbage before sync produces no writes and leaves the block idle
    send(8'h00, 0);
    send(8'h37, 1);
    send(8'hFF, 0);
    check("garbage_busy", 32'(busy), 32'd0);
    check("garbage_in_ready", 32'(bus.in_ready), 32'd1);
    check("garbage_writes", 32'(wr_count), 32'd0);

    // Back-to-back frame; byte 0 = 0x52, byte 10 = 0xA5 as data
    send_frame(3, 0, 1'b0, -1);
    check("frame1_count", 32'(frame_count), 32'd1);

    // Same data with random starvation gaps and a long hold mid-frame
    send_frame(3, 2, 1'b1, 7);
    check("frame2_count", 32'(frame_count), 32'd2);

    // Partial frame abandoned by reset
    send_sync(0);
    for (int k = 0; k < 20; k++) send_data(pat(k, 9), 0);
    step();
    reset = 1'b1;
    step();
    check("midrst_wr_en", 32'(bus.wr_en), 32'd0);
    check("midrst_frame_count", 32'(frame_count), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    step();
    send(8'h11, 0);
    check("midrst_idle_no_write", 32'(bus.wr_en), 32'd0);
    send_frame(5, 0, 1'b0, -1);
    check("after_rst_count", 32'(frame_count), 32'd1);

    // Frame counter runs to 255 and wraps to 0
    for (int f = 0; f < 254; f++) send_frame(f, 0, 1'b0, -1);
    check("count_255", 32'(frame_count), 32'd255);
    send_frame(77, 0, 1'b0, -1);
    check("count_wrap", 32'(frame_count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
